// File: rtl/regfile_sb.sv
// Parametrised integer register file with pending-write scoreboard and soft-clear sweep.
// Define REGFILE_BYPASS_EN to forward writeback data to the read ports.
module regfile_sb #(
    parameter int  XLEN  = 32,
    parameter int  NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    output logic            o_busy,
    output logic            o_clr_done,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_rs1_pend,
    output logic            o_rs2_pend,
    input  logic            i_iss_valid,
    input  logic [AW-1:0]   i_iss_rd,
    input  logic            i_rd_wren,
    input  logic [AW-1:0]   i_rd_addr,
    input  logic [XLEN-1:0] i_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW:0]      idx;
    logic [AW:0]      idx_nxt;
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend;

    logic wr_en;
    logic iss_en;
    logic clr_go;

    assign wr_en  = i_rd_wren && (i_rd_addr != '0) && (state != S_CLEAR);
    assign iss_en = i_iss_valid && (i_iss_rd != '0) && (state == S_IDLE);
    assign clr_go = (state == S_IDLE) && i_clear;

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        o_busy     = 1'b0;
        o_clr_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_clear) begin
                    state_nxt = S_CLEAR;
                    idx_nxt   = (AW+1)'(1);
                end
            end
            S_CLEAR: begin
                o_busy  = 1'b1;
                idx_nxt = idx + (AW+1)'(1);
                if (idx == (AW+1)'(NREGS-1))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                o_clr_done = 1'b1;
                state_nxt  = S_IDLE;
                idx_nxt    = (AW+1)'(1);
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = (AW+1)'(1);
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            idx   <= (AW+1)'(1);
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // The sweep owns the write path while clearing; idx stays in 1..NREGS-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (state == S_CLEAR) begin
            regs[idx[AW-1:0]] <= '0;
        end else if (wr_en) begin
            regs[i_rd_addr] <= i_rd_data;
        end
    end

    // Issue is applied after writeback so a same-cycle new producer keeps pend set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend <= '0;
        end else if (clr_go) begin
            pend <= '0;
        end else begin
            if (wr_en)
                pend[i_rd_addr] <= 1'b0;
            if (iss_en)
                pend[i_iss_rd] <= 1'b1;
        end
    end

    always_comb begin
        o_rs1_data = regs[i_rs1_addr];
        o_rs1_pend = pend[i_rs1_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (i_rs1_addr == i_rd_addr)) begin
            o_rs1_data = i_rd_data;
            o_rs1_pend = iss_en && (i_iss_rd == i_rs1_addr);
        end
`endif
        if (i_rs1_addr == '0) begin
            o_rs1_data = '0;
            o_rs1_pend = 1'b0;
        end
    end

    always_comb begin
        o_rs2_data = regs[i_rs2_addr];
        o_rs2_pend = pend[i_rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (i_rs2_addr == i_rd_addr)) begin
            o_rs2_data = i_rd_data;
            o_rs2_pend = iss_en && (i_iss_rd == i_rs2_addr);
        end
`endif
        if (i_rs2_addr == '0) begin
            o_rs2_data = '0;
            o_rs2_pend = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an array-based reference model.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    logic            busy;
    logic            clr_done;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_pend;
    logic            rs2_pend;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            rd_wren;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clear    (clear),
        .o_busy     (busy),
        .o_clr_done (clr_done),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .o_rs1_data (rs1_data),
        .o_rs2_data (rs2_data),
        .o_rs1_pend (rs1_pend),
        .o_rs2_pend (rs2_pend),
        .i_iss_valid(iss_valid),
        .i_iss_rd   (iss_rd),
        .i_rd_wren  (rd_wren),
        .i_rd_addr  (rd_addr),
        .i_rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: register contents, pending flags, sweep progress
    logic [XLEN-1:0] m_reg [NREGS];
    bit              m_pend [NREGS];
    bit              m_clearing;
    bit              m_done;
    int              m_sweep;

    bit obs_busy;
    bit obs_done;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_clearing = 1'b0;
        m_done     = 1'b0;
        m_sweep    = 1;
    endtask

    task automatic expect_port(input logic [AW-1:0] a, output logic [XLEN-1:0] d,
                               output logic p);
        d = m_reg[a];
        p = m_pend[a];
        if (BYP && rd_wren && rd_addr != 0 && rd_addr == a && !m_clearing) begin
            d = rd_data;
            p = iss_valid && iss_rd == a && !m_done;
        end
        if (a == 0) begin
            d = '0;
            p = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [XLEN-1:0] d;
        logic            p;
        expect_port(rs1_addr, d, p);
        chk("rs1_data", rs1_data, d);
        chk("rs1_pend", 32'(rs1_pend), 32'(p));
        expect_port(rs2_addr, d, p);
        chk("rs2_data", rs2_data, d);
        chk("rs2_pend", 32'(rs2_pend), 32'(p));
        chk("busy", 32'(busy), 32'(m_clearing));
        chk("clr_done", 32'(clr_done), 32'(m_done));
        obs_busy = busy;
        obs_done = clr_done;
    endtask

    task automatic model_edge();
        if (m_clearing) begin
            m_reg[m_sweep] = '0;
            if (m_sweep == NREGS - 1) begin
                m_clearing = 1'b0;
                m_done     = 1'b1;
            end
            m_sweep++;
        end else begin
            bit was_idle;
            was_idle = !m_done;
            m_done   = 1'b0;
            if (rd_wren && rd_addr != 0) begin
                m_reg[rd_addr]  = rd_data;
                m_pend[rd_addr] = 1'b0;
            end
            if (was_idle && iss_valid && iss_rd != 0)
                m_pend[iss_rd] = 1'b1;
            if (was_idle && clear) begin
                for (int i = 0; i < NREGS; i++)
                    m_pend[i] = 1'b0;
                m_clearing = 1'b1;
                m_sweep    = 1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        clear     = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        rd_wren   = 1'b0;
        rd_addr   = '0;
        rd_data   = '0;
    endtask

    task automatic write_reg(input int a, input logic [XLEN-1:0] v);
        idle_inputs();
        rd_wren = 1'b1;
        rd_addr = AW'(a);
        rd_data = v;
        cycle();
        idle_inputs();
    endtask

    task automatic load_all();
        for (int n = 1; n < NREGS; n++)
            write_reg(n, 32'h100 + 32'(n));
    endtask

    int nb;

    initial begin
        idle_inputs();
        rs1_addr = '0;
        rs2_addr = '0;
        rst_n    = 1'b0;
        model_reset();
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(clr_done), 32'd0);
        rst_n = 1'b1;
        #1;

        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = AW'(a);
            rs2_addr = AW'(NREGS - 1 - a);
            cycle();
        end

        write_reg(0, 32'hDEADBEEF);
        rs1_addr = '0;
        #1;
        chk("x0_zero", rs1_data, 32'h0);

        // issue x5, write it back two cycles later
        rs1_addr  = 5;
        iss_valid = 1'b1;
        iss_rd    = 5;
        cycle();
        idle_inputs();
        chk("pend5_set", 32'(rs1_pend), 32'd1);
        cycle();
        write_reg(5, 32'h12345678);
        chk("pend5_clr", 32'(rs1_pend), 32'd0);
        chk("x5_data", rs1_data, 32'h12345678);

        // same-cycle issue and writeback of x7
        rs2_addr  = 7;
        rd_wren   = 1'b1;
        rd_addr   = 7;
        rd_data   = 32'hA5A5A5A5;
        iss_valid = 1'b1;
        iss_rd    = 7;
        cycle();
        idle_inputs();
        chk("pend7_keep", 32'(rs2_pend), 32'd1);
        chk("x7_data", rs2_data, 32'hA5A5A5A5);

        // bypass: write x9 while it is pending and being read
        write_reg(9, 32'h00000099);
        iss_valid = 1'b1;
        iss_rd    = 9;
        cycle();
        idle_inputs();
        rs1_addr = 9;
        rd_wren  = 1'b1;
        rd_addr  = 9;
        rd_data  = 32'hCAFEF00D;
        #1;
        chk("byp_data", rs1_data, BYP ? 32'hCAFEF00D : 32'h00000099);
        chk("byp_pend", 32'(rs1_pend), BYP ? 32'd0 : 32'd1);
        cycle();
        idle_inputs();

        // full sweep with a dropped write and an ignored second clear
        load_all();
        clear = 1'b1;
        cycle();
        idle_inputs();
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            idle_inputs();
            if (k == 2) clear = 1'b1;
            if (k == 5) begin
                rd_wren = 1'b1;
                rd_addr = 3;
                rd_data = 32'h333;
            end
            cycle();
            if (!obs_busy) break;
            nb++;
        end
        idle_inputs();
        chk("busy_cycles", 32'(nb), 32'd31);
        chk("done_pulse", 32'(obs_done), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("no_rearm", 32'(obs_busy), 32'd0);
        end
        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = AW'(a);
            #1;
            chk("swept_zero", rs1_data, 32'h0);
            cycle();
        end

        // reset in the middle of a sweep
        load_all();
        clear = 1'b1;
        cycle();
        idle_inputs();
        for (int k = 0; k < 40 && m_sweep != 10; k++)
            cycle();
        chk("sweep_at_10", 32'(m_sweep), 32'd10);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = AW'(a);
            #1;
            chk("mid_rst_zero", rs1_data, 32'h0);
        end
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            chk("no_done_after_rst", 32'(obs_done), 32'd0);
        end

        // randomised traffic
        for (int k = 0; k < 600; k++) begin
            clear     = ($urandom_range(0, 79) == 0);
            iss_valid = $urandom_range(0, 1);
            iss_rd    = AW'($urandom);
            rd_wren   = $urandom_range(0, 1);
            rd_addr   = ($urandom_range(0, 3) == 0) ? iss_rd : AW'($urandom);
            rd_data   = $urandom;
            rs1_addr  = ($urandom_range(0, 2) == 0) ? rd_addr : AW'($urandom);
            rs2_addr  = ($urandom_range(0, 2) == 0) ? iss_rd : AW'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the RV32 core, successor to the fixed 32x32 two-read/one-write file.
- Adds configurable width and depth, a per-register pending-write scoreboard for hazard detection, and a sequential soft-clear engine for context flush.
- Sits between decode (read/issue) and writeback. Optionally forwards the writeback data to the read ports.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >= 4. Register 0 is hardwired to zero.
- AW, $clog2(NREGS), address width (derived; do not override).

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset: asynchronous, active-low
- i_clear  input  1  soft-clear request; sampled only in IDLE
- o_busy  output  1  high while the clear engine is running (CLEAR state)
- o_clr_done  output  1  one-cycle pulse when a clear completes
- i_rs1_addr  input  AW  read port 1 address
- i_rs2_addr  input  AW  read port 2 address
- o_rs1_data  output  XLEN  read port 1 data (combinational)
- o_rs2_data  output  XLEN  read port 2 data (combinational)
- o_rs1_pend  output  1  pending-write bit of i_rs1_addr
- o_rs2_pend  output  1  pending-write bit of i_rs2_addr
- i_iss_valid  input  1  an instruction writing i_iss_rd has issued
- i_iss_rd  input  AW  destination register of the issued instruction
- i_rd_wren  input  1  writeback enable
- i_rd_addr  input  AW  writeback address
- i_rd_data  input  XLEN  writeback data

Behaviour:
- Reset (async, i_rst_n=0):
  - All registers are 0 and all pending bits are 0.
  - FSM goes to IDLE; clear index = 1.
  - o_busy=0, o_clr_done=0.
- Reads are combinational.
  - Address 0 always returns 0 with pend=0.
  - Otherwise the read returns the stored value and the pending bit.
- Write:
  - On a rising edge with i_rd_wren=1, i_rd_addr!=0 and state!=CLEAR, the register takes i_rd_data.
  - Register 0 is never written.
- Scoreboard (one bit per register; bit 0 is constant 0):
  - Set: i_iss_valid=1, i_iss_rd!=0, state==IDLE sets pend[i_iss_rd].
  - Clear: a qualifying writeback clears pend[i_rd_addr].
  - Same register issued and written back in the same cycle: pend stays 1 (the new producer wins) and the data is still written.
  - Writeback to a register whose pend is already 0 is allowed; pend stays 0.
- FSM states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR when i_clear=1. On that edge all pending bits clear and the index loads 1.
  - CLEAR: zero reg[index] every cycle and increment the index. After writing index NREGS-1, go to DONE. CLEAR lasts NREGS-1 cycles.
  - DONE: o_clr_done=1 for exactly this one cycle, then go to IDLE.
  - o_busy=1 only in CLEAR.
  - i_clear is ignored in CLEAR and DONE (no re-arm, no queuing).
  - In CLEAR, writebacks and issues are dropped. Reads stay live: a register not yet reached keeps its old value, a register already swept reads 0.
- Reset asserted mid-clear: immediate return to IDLE with all registers at 0. No o_clr_done pulse.
- Width: the index is AW+1 bits wide, so the compare against NREGS-1 cannot wrap.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - A read port whose address equals i_rd_addr (!=0), with i_rd_wren=1 and state!=CLEAR, returns i_rd_data in the same cycle.
  - That port's pend output reads 0, unless i_iss_valid targets the same register in that cycle, in which case it reads 1.
- Undefined:
  - Reads return the registered value only; the written data is visible from the cycle after the write.
  - pend reflects the registered bit.

Test Plan:
- Reset, then read all addresses: every data output reads 0 and every pend reads 0. Write x0=0xDEADBEEF, then read x0: 0x00000000.
- Issue rd=5, then two cycles later write x5=0x12345678: pend5 reads 1 after the issue edge, 0 after the write edge, and the read returns 0x12345678.
- Same cycle: issue rd=7 and write x7=0xA5A5A5A5: next cycle pend7=1 and x7=0xA5A5A5A5.
- Load x1..x31 with 0x100+n, then pulse i_clear. Expect:
  - o_busy high for exactly 31 cycles, then o_clr_done high for 1 cycle.
  - All registers read 0.
  - A write to x3 issued during busy is lost (reads 0).
  - A second i_clear during busy starts no second sweep.
- Start a clear, then assert i_rst_n=0 at sweep index 10: immediately o_busy=0, all registers 0, and o_clr_done never pulses.
- With REGFILE_BYPASS_EN: write x9=0xCAFEF00D while rs1_addr=9 and pend9 was set: in the same cycle o_rs1_data=0xCAFEF00D and o_rs1_pend=0. Without the macro, the same cycle returns the old value.
